// File: rtl/mmcm_phaseshift_multi.sv
// Multi-channel MMCM fine phase-shift stepper: one PSEN/PSDONE step engine per MMCM with timeout and retargeting.
// Define MMCM_PS_WRAP_EN for modulo-pPERIOD_STEPS positions with shortest-path stepping (default: linear, clamped).
module mmcm_phaseshift_multi #(
  parameter int pCHANNELS     = 2,
  parameter int pSTEP_WIDTH   = 16,
  parameter int pMAX_STEP     = 32767,
  parameter int pTIMEOUT      = 255,
  parameter int pPERIOD_STEPS = 1120
) (
  input  logic                             clk_usb,
  input  logic                             reset_n,
  input  logic [pCHANNELS*pSTEP_WIDTH-1:0] I_step_index,
  input  logic [pCHANNELS-1:0]             I_load,
  input  logic                             I_clear_timeout,
  output logic [pCHANNELS-1:0]             O_psen,
  output logic [pCHANNELS-1:0]             O_psincdec,
  input  logic [pCHANNELS-1:0]             I_psdone,
  output logic [pCHANNELS*pSTEP_WIDTH-1:0] O_position,
  output logic [pCHANNELS-1:0]             O_done,
  output logic [pCHANNELS-1:0]             O_timeout,
  output logic                             O_busy
);

  typedef logic signed [pSTEP_WIDTH-1:0] step_t;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_WAIT   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam int              LP_CW       = $clog2(pTIMEOUT + 1);
  localparam logic [LP_CW-1:0] LP_CNT_LAST = LP_CW'(pTIMEOUT - 1);
  localparam logic [LP_CW-1:0] LP_CNT_ONE  = LP_CW'(1);
  localparam step_t           LP_ONE      = step_t'(1);

  // Reject parameter sets whose clamp or period cannot be held in the signed position.
  if ((pMAX_STEP >= (32'd1 << (pSTEP_WIDTH - 1))) ||
      (pPERIOD_STEPS >= (32'd1 << (pSTEP_WIDTH - 1)))) begin : g_bad_cfg
    $error("mmcm_phaseshift_multi: pMAX_STEP/pPERIOD_STEPS exceed pSTEP_WIDTH");
  end

`ifdef MMCM_PS_WRAP_EN
  localparam step_t LP_PMAX = step_t'(pPERIOD_STEPS - 1);

  function automatic step_t f_target(input step_t v);
    int t;
    t = int'(v) % pPERIOD_STEPS;
    if (t < 0) t = t + pPERIOD_STEPS;
    return step_t'(t);
  endfunction

  // Forward distance of at most half a period (tie included) steps up.
  function automatic logic f_dir(input step_t tgt, input step_t pos);
    int d;
    d = (int'(tgt) - int'(pos)) % pPERIOD_STEPS;
    if (d < 0) d = d + pPERIOD_STEPS;
    return (d <= (pPERIOD_STEPS / 2));
  endfunction

  function automatic step_t f_step(input step_t pos, input logic up);
    if (up) return (pos == LP_PMAX) ? step_t'(0) : pos + LP_ONE;
    else    return (pos == step_t'(0)) ? LP_PMAX : pos - LP_ONE;
  endfunction
`else
  localparam step_t LP_MAX = step_t'(pMAX_STEP);
  localparam step_t LP_MIN = step_t'(-pMAX_STEP);

  function automatic step_t f_target(input step_t v);
    if (v > LP_MAX)      return LP_MAX;
    else if (v < LP_MIN) return LP_MIN;
    else                 return v;
  endfunction

  function automatic logic f_dir(input step_t tgt, input step_t pos);
    return (tgt > pos);
  endfunction

  function automatic step_t f_step(input step_t pos, input logic up);
    return up ? (pos + LP_ONE) : (pos - LP_ONE);
  endfunction
`endif

  logic [pCHANNELS-1:0] w_done_nxt;
  logic                 r_busy;

  genvar gi;
  for (gi = 0; gi < pCHANNELS; gi++) begin : g_ch
    state_t           r_state, w_state_nxt;
    step_t            r_target, r_pos, w_target_fsm, w_target_nxt, w_pos_nxt, w_step_in;
    logic [LP_CW-1:0] r_cnt, w_cnt_nxt;
    logic             r_go, r_dir, r_psen, r_timeout, r_done;
    logic             w_dir_nxt, w_psen_nxt, w_timeout_fsm, w_timeout_nxt, w_done_c;

    assign w_step_in = step_t'(I_step_index[gi*pSTEP_WIDTH +: pSTEP_WIDTH]);

    // Next-state and next-register logic; a load overrides an abort on the same edge.
    always_comb begin
      w_state_nxt   = r_state;
      w_target_fsm  = r_target;
      w_pos_nxt     = r_pos;
      w_cnt_nxt     = r_cnt;
      w_dir_nxt     = r_dir;
      w_psen_nxt    = 1'b0;
      w_timeout_fsm = I_clear_timeout ? 1'b0 : r_timeout;
      case (r_state)
        S_IDLE: begin
          if (r_go && (r_target != r_pos)) begin
            w_state_nxt = S_STEP;
            w_dir_nxt   = f_dir(r_target, r_pos);
            w_psen_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_STEP: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
        S_WAIT: begin
          if (I_psdone[gi]) begin
            w_pos_nxt   = f_step(r_pos, r_dir);
            w_state_nxt = S_SETTLE;
          end else if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_fsm = 1'b1;
            w_target_fsm  = r_pos;
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end
        S_SETTLE: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
      w_target_nxt  = I_load[gi] ? f_target(w_step_in) : w_target_fsm;
      w_timeout_nxt = I_load[gi] ? 1'b0 : w_timeout_fsm;
      w_done_c      = (w_state_nxt == S_IDLE) && (w_target_nxt == w_pos_nxt);
    end

    // Engine state; r_go registers the IDLE move decision one cycle ahead.
    always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
        r_state   <= S_IDLE;
        r_target  <= '0;
        r_pos     <= '0;
        r_cnt     <= '0;
        r_go      <= 1'b0;
        r_dir     <= 1'b0;
        r_psen    <= 1'b0;
        r_timeout <= 1'b0;
        r_done    <= 1'b1;
      end else begin
        r_state   <= w_state_nxt;
        r_target  <= w_target_nxt;
        r_pos     <= w_pos_nxt;
        r_cnt     <= w_cnt_nxt;
        r_go      <= (r_target != r_pos);
        r_dir     <= w_dir_nxt;
        r_psen    <= w_psen_nxt;
        r_timeout <= w_timeout_nxt;
        r_done    <= w_done_c;
      end
    end

    assign w_done_nxt[gi]                               = w_done_c;
    assign O_psen[gi]                                   = r_psen;
    assign O_psincdec[gi]                               = r_dir;
    assign O_timeout[gi]                                = r_timeout;
    assign O_done[gi]                                   = r_done;
    assign O_position[gi*pSTEP_WIDTH +: pSTEP_WIDTH]    = r_pos;
  end

  // Busy follows the registered done vector cycle for cycle.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= ~(&w_done_nxt);
    end
  end

  assign O_busy = r_busy;

endmodule
